// File: rtl/fp16_systolic_tile_sequencer.sv
// Tile sequencer for the SIZE x SIZE FP16 systolic array.
// Clears the accumulators, streams K activation/weight vectors from the
// operand buffers through a diagonal skew, drains the wavefront, pulses done.
// Optional feature macro: SEQ_PERF_CNT_EN (busy-cycle performance counter).
module fp16_systolic_tile_sequencer #(
    parameter int SIZE    = 8,
    parameter int KW      = 10,
    parameter int MAC_LAT = 2,
    parameter int PERF_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [KW-1:0]      k_len,
    input  logic               stall,
    input  logic               abort,
    output logic               a_rd_en,
    output logic [KW-1:0]      a_rd_addr,
    input  logic [16*SIZE-1:0] a_rd_data,
    output logic               w_rd_en,
    output logic [KW-1:0]      w_rd_addr,
    input  logic [16*SIZE-1:0] w_rd_data,
    output logic [16*SIZE-1:0] arr_a_in,
    output logic [16*SIZE-1:0] arr_w_in,
    output logic               arr_enable,
    output logic               arr_acc_clear,
    output logic               busy,
    output logic               done,
    output logic [PERF_W-1:0]  perf_busy_cycles
);

    // Cycles for the last vector to cross the skew and the array, plus MAC latency.
    localparam int DRAIN_LEN = 1 + 2 * (SIZE - 1) + MAC_LAT;
    localparam int DW        = $clog2(DRAIN_LEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t              state, state_nxt;
    logic [KW-1:0]       k_reg;
    logic [KW-1:0]       addr;
    logic [DW-1:0]       drain_cnt;
    logic                rd_pend;
    logic                hold_valid;
    logic [16*SIZE-1:0]  a_hold, w_hold;
    logic [16*SIZE-1:0]  a_cur, w_cur;
    logic                active;
    logic                adv;
    logic                accept;
    logic                rd_en;

    assign active = (state == S_CLEAR) || (state == S_FEED) || (state == S_DRAIN);
    assign adv    = active && !stall;
    assign accept = (state == S_IDLE) && start && !abort;
    assign rd_en  = (state == S_FEED) && !stall;

    // Next-state and control outputs decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_nxt     = state;
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
        arr_enable    = adv;
        arr_acc_clear = (state == S_CLEAR) && !stall;
        case (state)
            S_IDLE:  if (accept) state_nxt = (k_len == '0) ? S_DONE : S_CLEAR;
            S_CLEAR: if (!stall) state_nxt = S_FEED;
            S_FEED:  if (!stall && addr == k_reg - KW'(1)) state_nxt = S_DRAIN;
            S_DRAIN: if (!stall && drain_cnt == DW'(DRAIN_LEN - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    assign a_rd_en   = rd_en;
    assign w_rd_en   = rd_en;
    assign a_rd_addr = addr;
    assign w_rd_addr = addr;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Latched depth, shared read address and drain counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_reg     <= '0;
            addr      <= '0;
            drain_cnt <= '0;
        end else if (abort) begin
            addr      <= '0;
            drain_cnt <= '0;
        end else if (accept) begin
            k_reg     <= k_len;
            addr      <= '0;
            drain_cnt <= '0;
        end else begin
            if (rd_en) addr <= addr + KW'(1);
            if (state == S_DRAIN && !stall) drain_cnt <= drain_cnt + DW'(1);
        end
    end

    // Read-return tracking; a vector returning into a stalled cycle is parked.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            rd_pend    <= 1'b0;
            hold_valid <= 1'b0;
            a_hold     <= '0;
            w_hold     <= '0;
        end else begin
            rd_pend <= rd_en;
            if (rd_pend && stall) begin
                a_hold     <= a_rd_data;
                w_hold     <= w_rd_data;
                hold_valid <= 1'b1;
            end else if (adv) begin
                hold_valid <= 1'b0;
            end
        end
    end

    // Vector entering the skew this cycle: parked copy, fresh return, or zeros.
    always_comb begin
        a_cur = '0;
        w_cur = '0;
        if (hold_valid) begin
            a_cur = a_hold;
            w_cur = w_hold;
        end else if (rd_pend) begin
            a_cur = a_rd_data;
            w_cur = w_rd_data;
        end
    end

    // Diagonal skew: lane n is delayed n unstalled cycles; lane 0 passes straight.
    for (genvar n = 0; n < SIZE; n++) begin : g_lane
        if (n == 0) begin : g_direct
            assign arr_a_in[15:0] = a_cur[15:0];
            assign arr_w_in[15:0] = w_cur[15:0];
        end else begin : g_delay
            logic [15:0] a_pipe [n];
            logic [15:0] w_pipe [n];

            // Shift the lane delay line on every unstalled active cycle.
            always_ff @(posedge clk) begin
                // NOTE: the delay lines are reset so abort leaves no stale operands behind.
                if (rst || abort) begin
                    for (int s = 0; s < n; s++) begin
                        a_pipe[s] <= '0;
                        w_pipe[s] <= '0;
                    end
                end else if (adv) begin
                    a_pipe[0] <= a_cur[16*n +: 16];
                    w_pipe[0] <= w_cur[16*n +: 16];
                    for (int s = 1; s < n; s++) begin
                        a_pipe[s] <= a_pipe[s-1];
                        w_pipe[s] <= w_pipe[s-1];
                    end
                end
            end

            assign arr_a_in[16*n +: 16] = a_pipe[n-1];
            assign arr_w_in[16*n +: 16] = w_pipe[n-1];
        end
    end

`ifdef SEQ_PERF_CNT_EN
    // Saturating count of unstalled busy cycles; restarts on each accepted tile.
    always_ff @(posedge clk) begin
        if (rst)                                         perf_busy_cycles <= '0;
        else if (accept)                                 perf_busy_cycles <= '0;
        else if (busy && !stall && perf_busy_cycles != '1) perf_busy_cycles <= perf_busy_cycles + PERF_W'(1);
    end
`else
    assign perf_busy_cycles = '0;
`endif

endmodule

// File: tb/tb_fp16_systolic_tile_sequencer.sv
// Directed bench for fp16_systolic_tile_sequencer: operand buffer models,
// an integer systolic array model fed by the skewed outputs, and a vector table.
module tb_fp16_systolic_tile_sequencer;

    localparam int SIZE   = 8;
    localparam int KW     = 10;
    localparam int PERF_W = 32;

`ifdef SEQ_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [KW-1:0]      k_len;
    logic               stall;
    logic               abort;
    logic               a_rd_en, w_rd_en;
    logic [KW-1:0]      a_rd_addr, w_rd_addr;
    logic [16*SIZE-1:0] a_rd_data, w_rd_data;
    logic [16*SIZE-1:0] arr_a_in, arr_w_in;
    logic               arr_enable, arr_acc_clear, busy, done;
    logic [PERF_W-1:0]  perf_busy_cycles;

    fp16_systolic_tile_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .stall(stall), .abort(abort),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .arr_a_in(arr_a_in), .arr_w_in(arr_w_in), .arr_enable(arr_enable),
        .arr_acc_clear(arr_acc_clear), .busy(busy), .done(done),
        .perf_busy_cycles(perf_busy_cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Operand buffers: one-cycle read latency, garbage when not read.
    logic [15:0] a_mem [16][SIZE];
    logic [15:0] w_mem [16][SIZE];

    always @(posedge clk) begin
        for (int i = 0; i < SIZE; i++) begin
            a_rd_data[16*i +: 16] <= a_rd_en ? a_mem[a_rd_addr[3:0]][i] : 16'hBEEF;
            w_rd_data[16*i +: 16] <= w_rd_en ? w_mem[w_rd_addr[3:0]][i] : 16'hBEEF;
        end
    end

    // Integer systolic array: a flows right, w flows down, one hop per enabled cycle.
    logic [15:0] ah [SIZE][SIZE];
    logic [15:0] wv [SIZE][SIZE];
    longint      acc_m [SIZE][SIZE];

    always @(posedge clk) begin
        longint av, wt;
        if (arr_enable) begin
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    av = (j == 0) ? longint'(arr_a_in[16*i +: 16]) : longint'(ah[i][j-1]);
                    wt = (i == 0) ? longint'(arr_w_in[16*j +: 16]) : longint'(wv[i-1][j]);
                    ah[i][j] <= av[15:0];
                    wv[i][j] <= wt[15:0];
                    acc_m[i][j] <= arr_acc_clear ? 64'sd0 : acc_m[i][j] + av * wt;
                end
            end
        end
    end

    typedef struct {
        int k;
        int pat;          // 0: A=1.0 W=2.0 everywhere, 1: distinct per vector/lane
        int stall_at;
        int stall_n;
        int abort_at;     // 0 = no abort
        bit abort_start;
        bit start_in_done;
        int exp_done;     // 0 = no done expected
        int exp_clear;    // 0 = no clear expected
        int exp_reads;
        int exp_busy;
        int exp_perf;
    } vec_t;

    task automatic load_mem(input int pat);
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < SIZE; i++) begin
                a_mem[k][i] = (pat == 0) ? 16'h3C00 : 16'((k + 1) * 16 + i + 1);
                w_mem[k][i] = (pat == 0) ? 16'h4000 : 16'((k + 1) * 8 + i + 2);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, done_cyc, clear_cyc, reads, bad_addr, busy_n, first_rd;
        int a_first [SIZE];
        int a_nz    [SIZE];
        int w_first [SIZE];
        int w_nz    [SIZE];
        int nbad_acc;
        longint e;
        load_mem(v.pat);
        for (int i = 0; i < SIZE; i++) begin
            a_first[i] = 0; a_nz[i] = 0; w_first[i] = 0; w_nz[i] = 0;
        end
        done_cyc = 0; clear_cyc = 0; reads = 0; bad_addr = 0; busy_n = 0; first_rd = 0;
        start = 1'b1;
        k_len = KW'(v.k);
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (cyc <= 200) begin
            stall = (v.stall_n > 0) && (cyc >= v.stall_at) && (cyc < v.stall_at + v.stall_n);
            abort = (cyc == v.abort_at);
            start = (v.abort_start && cyc == v.abort_at) || (v.start_in_done && cyc == v.exp_done);
            @(negedge clk);
            if (busy) busy_n++;
            if (arr_acc_clear && clear_cyc == 0) clear_cyc = cyc;
            if (a_rd_en || w_rd_en) begin
                if (first_rd == 0) first_rd = cyc;
                if (!a_rd_en || !w_rd_en || a_rd_addr != KW'(reads) || w_rd_addr != KW'(reads))
                    bad_addr++;
                reads++;
            end
            for (int i = 0; i < SIZE; i++) begin
                if (arr_a_in[16*i +: 16] != 16'h0) begin
                    a_nz[i]++;
                    if (a_first[i] == 0) a_first[i] = cyc;
                end
                if (arr_w_in[16*i +: 16] != 16'h0) begin
                    w_nz[i]++;
                    if (w_first[i] == 0) w_first[i] = cyc;
                end
            end
            if (done) done_cyc = cyc;
            if (done || !busy) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
        check($sformatf("v%0d_clear_cycle", idx), clear_cyc, v.exp_clear);
        check($sformatf("v%0d_reads", idx), reads, v.exp_reads);
        check($sformatf("v%0d_addr_errs", idx), bad_addr, 0);
        check($sformatf("v%0d_busy_cycles", idx), busy_n, v.exp_busy);
        if (v.exp_reads > 0)
            check($sformatf("v%0d_first_read", idx), first_rd, v.exp_clear + 1);
        if (v.abort_at > 0) begin
            check($sformatf("v%0d_idle_after_abort", idx), cyc, v.abort_at + 1);
            check($sformatf("v%0d_abort_ctl_zero", idx),
                  {a_rd_en, w_rd_en, arr_enable, arr_acc_clear, done}, 0);
            check($sformatf("v%0d_abort_a_zero", idx), (arr_a_in == '0), 1);
            check($sformatf("v%0d_abort_w_zero", idx), (arr_w_in == '0), 1);
        end
        if (v.k == 1 && v.stall_n == 0) begin
            for (int i = 0; i < SIZE; i++) begin
                check($sformatf("v%0d_skew_a%0d_cycle", idx, i), a_first[i], 3 + i);
                check($sformatf("v%0d_skew_a%0d_count", idx, i), a_nz[i], 1);
                check($sformatf("v%0d_skew_w%0d_cycle", idx, i), w_first[i], 3 + i);
                check($sformatf("v%0d_skew_w%0d_count", idx, i), w_nz[i], 1);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_idle_next", idx), busy, 0);
        check($sformatf("v%0d_perf", idx), perf_busy_cycles, PERF_ON ? v.exp_perf : 0);
        if (v.abort_at == 0 && v.k > 0) begin
            nbad_acc = 0;
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    e = 0;
                    for (int k = 0; k < v.k; k++)
                        e += longint'(a_mem[k][i]) * longint'(w_mem[k][j]);
                    if (acc_m[i][j] != e) nbad_acc++;
                end
            end
            check($sformatf("v%0d_acc_bad_cells", idx), nbad_acc, 0);
            e = 0;
            for (int k = 0; k < v.k; k++)
                e += longint'(a_mem[k][SIZE-1]) * longint'(w_mem[k][SIZE-1]);
            check($sformatf("v%0d_acc_corner", idx), acc_m[SIZE-1][SIZE-1], e);
        end
    endtask

    vec_t vecs [9];

    initial begin
        //        k pat st sn ab as sd done clr rd busy perf
        vecs[0] = '{4, 0, 0, 0, 0, 0, 1, 23, 1, 4, 23, 23};
        vecs[1] = '{1, 1, 0, 0, 0, 0, 0, 20, 1, 1, 20, 20};
        vecs[2] = '{0, 1, 0, 0, 0, 0, 0,  1, 0, 0,  1,  1};
        vecs[3] = '{4, 0, 3, 3, 0, 0, 0, 26, 1, 4, 26, 23};
        vecs[4] = '{4, 1, 0, 0, 4, 0, 0,  0, 1, 3,  4,  4};
        vecs[5] = '{4, 1, 0, 0, 4, 1, 0,  0, 1, 3,  4,  4};
        vecs[6] = '{4, 1, 0, 0, 0, 0, 0, 23, 1, 4, 23, 23};
        vecs[7] = '{3, 1, 1, 2, 0, 0, 0, 24, 3, 3, 24, 22};
        vecs[8] = '{5, 1, 10, 1, 0, 0, 0, 25, 1, 5, 25, 24};

        rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0; k_len = '0;
        load_mem(0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_ctl", {busy, done, a_rd_en, w_rd_en, arr_enable, arr_acc_clear}, 0);
        check("reset_arr_a", (arr_a_in == '0), 1);
        check("reset_arr_w", (arr_w_in == '0), 1);
        check("reset_perf", perf_busy_cycles, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // start together with abort while idle must be ignored
        start = 1'b1; abort = 1'b1; k_len = KW'(4);
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("idle_abort_start_ignored", busy, 0);

        for (int n = 0; n < 9; n++) run_vec(vecs[n], n);

        // reset in the middle of a tile behaves like abort and clears perf
        start = 1'b1; k_len = KW'(4);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ctl", {a_rd_en, arr_enable, arr_acc_clear, done}, 0);
        check("rst_mid_arr", (arr_a_in == '0) && (arr_w_in == '0), 1);
        check("rst_mid_perf", perf_busy_cycles, 0);
        @(posedge clk);
        #1;
        run_vec(vecs[0], 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
